// File: rtl/pic_int_sequencer.sv
// Interrupt request/service sequencer for an 8-level PIC.
// It captures IR requests into IRR, applies IMR masking and rotating
// fully-nested priority, and raises INT. It then runs the two-pulse INTA
// handshake, drives the vector byte, and keeps ISR under EOI, AEOI and
// rotation commands.
module pic_int_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int INTA_PULSES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       ltim,
    input  logic       aeoi,
    input  logic       auto_rot,
    input  logic [7:0] imr,
    input  logic [4:0] t_base,
    input  logic       eoi_cmd,
    input  logic       eoi_spec,
    input  logic       eoi_rot,
    input  logic       set_prio,
    input  logic [2:0] eoi_level,
    input  logic       inta_n,
    output logic       int_o,
    output logic [7:0] dout,
    output logic       dout_en,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic       busy
);

    // Only the two-pulse acknowledge exists, and a single flop is not a synchroniser.
    if (SYNC_STAGES < 2 || INTA_PULSES != 2) begin : g_bad_param
        $error("pic_int_sequencer: needs SYNC_STAGES >= 2 and INTA_PULSES == 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK1,
        S_ACK2
    } state_e;

    // Result of a priority scan: rank 0 is the highest priority level.
    typedef struct packed {
        logic       found;
        logic [2:0] level;
        logic [2:0] rank;
    } prio_t;

    // The scan starts at lp+1 and wraps around to lp, which is the lowest priority.
    function automatic prio_t find_highest(input logic [7:0] vec, input logic [2:0] lp);
        prio_t      r;
        logic [2:0] lvl;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            lvl = lp + 3'd1 + 3'(k);
            if (!r.found && vec[lvl]) begin
                r.found = 1'b1;
                r.level = lvl;
                r.rank  = 3'(k);
            end
        end
        return r;
    endfunction

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] irs;
    logic [7:0] irs_prev_q;
    logic       inta_q;
    logic       inta_fall;
    logic       inta_rise;

    logic [7:0] irr_q, irr_d, irr_nxt;
    logic [7:0] isr_q, isr_d;
    logic [2:0] lp_q, lp_d;

    state_e     state_q;
    logic [2:0] win_q;
    logic       spur_q;
    logic       int_q;
    logic [7:0] dout_q;
    logic       dout_en_q;
    logic       busy_q;

    prio_t      req_top;
    prio_t      isr_top;
    logic       cand_valid;
    logic       ack_take;
    logic       aeoi_done;

    // IR synchroniser chain, IR edge history and the single INTA sample register.
    // NOTE: all state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the stage array is plain flops rather than a RAM, so it is reset like any register.
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            irs_prev_q <= '0;
            // The idle level of inta_n is high, so reset does not fake a fall.
            inta_q     <= 1'b1;
        end else begin
            sync_q[0] <= ir;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            irs_prev_q <= irs;
            inta_q     <= inta_n;
        end
    end

    assign irs       = sync_q[SYNC_STAGES-1];
    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;

    // Request capture before the acknowledge clear. Priority is resolved on these fresh
    // requests, so INT follows the synchroniser output by one register stage.
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        irr_nxt = irr_q;
        if (ltim) begin
            irr_nxt = irs;
        end else begin
            if (state_q == S_IDLE) irr_nxt = irr_nxt & irs;
            irr_nxt = irr_nxt | (irs & ~irs_prev_q);
        end
    end

    assign req_top    = find_highest(irr_nxt & ~imr, lp_q);
    assign isr_top    = find_highest(isr_q, lp_q);
    // Fully nested: any in-service level of equal or higher priority blocks the candidate.
    assign cand_valid = req_top.found && (!isr_top.found || (req_top.rank < isr_top.rank));
    assign ack_take   = (state_q == S_IDLE) && inta_fall && cand_valid;
    assign aeoi_done  = (state_q == S_ACK2) && inta_rise && aeoi && !spur_q;

    // Next IRR/ISR/priority pointer. EOI works on the pre-set ISR, then the acknowledge set
    // is applied on top. set_prio comes last so that it owns lp when it coincides with an EOI.
    always_comb begin
        irr_d = irr_nxt;
        isr_d = isr_q;
        lp_d  = lp_q;
        if (ack_take) irr_d[req_top.level] = 1'b0;
        if (eoi_cmd) begin
            if (eoi_spec) begin
                isr_d[eoi_level] = 1'b0;
                if (eoi_rot) lp_d = eoi_level;
            end else if (isr_top.found) begin
                isr_d[isr_top.level] = 1'b0;
                if (eoi_rot) lp_d = isr_top.level;
            end
        end
        if (aeoi_done) begin
            isr_d[win_q] = 1'b0;
            if (auto_rot) lp_d = win_q;
        end
        if (ack_take) isr_d[req_top.level] = 1'b1;
        if (set_prio) lp_d = eoi_level;
    end

    // Request, in-service and lowest-priority registers. After reset IR0 is the highest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr_q <= '0;
            isr_q <= '0;
            lp_q  <= 3'd7;
        end else begin
            irr_q <= irr_d;
            isr_q <= isr_d;
            lp_q  <= lp_d;
        end
    end

    // Acknowledge FSM with registered INT, vector and bus-enable outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            win_q     <= 3'd0;
            spur_q    <= 1'b0;
            int_q     <= 1'b0;
            dout_q    <= 8'h00;
            dout_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (inta_fall) begin
                        // With no valid candidate left, answer with the spurious level 7.
                        win_q   <= cand_valid ? req_top.level : 3'd7;
                        spur_q  <= !cand_valid;
                        int_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_ACK1;
                    end else begin
                        int_q <= cand_valid;
                    end
                end
                S_ACK1: begin
                    if (inta_fall) begin
                        dout_q    <= {t_base, win_q};
                        dout_en_q <= 1'b1;
                        state_q   <= S_ACK2;
                    end
                end
                S_ACK2: begin
                    if (inta_rise) begin
                        dout_en_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign int_o   = int_q;
    assign dout    = dout_q;
    assign dout_en = dout_en_q;
    assign irr     = irr_q;
    assign isr     = isr_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Directed bench for pic_int_sequencer. A vector table runs the main
// nested and rotating priority flow. Hand-written sequences then cover
// AEOI with auto-rotate, the level-mode spurious acknowledge, masking,
// and a reset in the middle of an acknowledge.
module tb_pic_int_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir;
    logic       ltim, aeoi, auto_rot;
    logic [7:0] imr;
    logic [4:0] t_base;
    logic       eoi_cmd, eoi_spec, eoi_rot, set_prio;
    logic [2:0] eoi_level;
    logic       inta_n;
    logic       int_o, dout_en, busy;
    logic [7:0] dout, irr, isr;

    int checks   = 0;
    int failures = 0;

    // Command nibble layout: {eoi_cmd, eoi_spec, eoi_rot, set_prio}.
    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_EOI  = 4'b1000;
    localparam logic [3:0] C_SPEC = 4'b1100;
    localparam logic [3:0] C_ROT  = 4'b1010;

    typedef struct {
        string      name;
        int         cyc;
        logic [7:0] ir;
        logic       inta_n;
        logic [3:0] cmd;
        logic [2:0] lvl;
        logic [7:0] e_irr;
        logic [7:0] e_isr;
        logic       e_int;
        logic       e_busy;
        logic       e_den;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs[$];

    pic_int_sequencer #(.SYNC_STAGES(2), .INTA_PULSES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir        (ir),
        .ltim      (ltim),
        .aeoi      (aeoi),
        .auto_rot  (auto_rot),
        .imr       (imr),
        .t_base    (t_base),
        .eoi_cmd   (eoi_cmd),
        .eoi_spec  (eoi_spec),
        .eoi_rot   (eoi_rot),
        .set_prio  (set_prio),
        .eoi_level (eoi_level),
        .inta_n    (inta_n),
        .int_o     (int_o),
        .dout      (dout),
        .dout_en   (dout_en),
        .irr       (irr),
        .isr       (isr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input int cyc, input logic [7:0] ir_v, input logic inta_v,
                       input logic [3:0] cmd, input logic [2:0] lvl, input logic [7:0] e_irr,
                       input logic [7:0] e_isr, input logic e_int, input logic e_busy,
                       input logic e_den, input logic [7:0] e_dout);
        vec_t v;
        v.name = nm;   v.cyc = cyc;     v.ir = ir_v;     v.inta_n = inta_v;
        v.cmd = cmd;   v.lvl = lvl;     v.e_irr = e_irr; v.e_isr = e_isr;
        v.e_int = e_int; v.e_busy = e_busy; v.e_den = e_den; v.e_dout = e_dout;
        vecs.push_back(v);
    endtask

    task automatic pulse_inta(input logic level);
        inta_n = level;
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0;  ir = 8'h00;   ltim = 1'b0;  aeoi = 1'b0;  auto_rot = 1'b0;
        imr = 8'h00;   t_base = 5'b01000;
        eoi_cmd = 1'b0; eoi_spec = 1'b0; eoi_rot = 1'b0; set_prio = 1'b0;
        eoi_level = 3'd0; inta_n = 1'b1;

        // Main flow. The vector is {01000, level}, so it reads 0x40 + level.
        //   name            cyc ir     inta cmd     lvl  irr    isr    int  busy den  dout
        add("idle",           3, 8'h00, 1, C_NONE, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add("ir3_req",        3, 8'h08, 1, C_NONE, 0, 8'h08, 8'h00, 1, 0, 0, 8'h00);
        add("ir3_fall1",      1, 8'h08, 0, C_NONE, 0, 8'h00, 8'h08, 0, 1, 0, 8'h00);
        add("ir3_rise1",      1, 8'h08, 1, C_NONE, 0, 8'h00, 8'h08, 0, 1, 0, 8'h00);
        add("ir3_fall2",      1, 8'h08, 0, C_NONE, 0, 8'h00, 8'h08, 0, 1, 1, 8'h43);
        add("ir3_hold2",      1, 8'h08, 0, C_NONE, 0, 8'h00, 8'h08, 0, 1, 1, 8'h43);
        add("ir3_rise2",      1, 8'h08, 1, C_NONE, 0, 8'h00, 8'h08, 0, 0, 0, 8'h00);
        add("ir3_no_retrig",  2, 8'h08, 1, C_NONE, 0, 8'h00, 8'h08, 0, 0, 0, 8'h00);
        add("eoi_ns_ir3",     1, 8'h00, 1, C_EOI,  0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add("ir2_ir5_req",    3, 8'h24, 1, C_NONE, 0, 8'h24, 8'h00, 1, 0, 0, 8'h00);
        add("ir2_fall1",      1, 8'h24, 0, C_NONE, 0, 8'h20, 8'h04, 0, 1, 0, 8'h00);
        add("ir2_rise1",      1, 8'h24, 1, C_NONE, 0, 8'h20, 8'h04, 0, 1, 0, 8'h00);
        add("ir2_fall2",      1, 8'h24, 0, C_NONE, 0, 8'h20, 8'h04, 0, 1, 1, 8'h42);
        add("ir2_rise2",      1, 8'h24, 1, C_NONE, 0, 8'h20, 8'h04, 0, 0, 0, 8'h00);
        add("ir1_nests",      3, 8'h26, 1, C_NONE, 0, 8'h22, 8'h04, 1, 0, 0, 8'h00);
        add("ir1_withdrawn",  3, 8'h20, 1, C_NONE, 0, 8'h20, 8'h04, 0, 0, 0, 8'h00);
        add("ir6_blocked",    3, 8'h60, 1, C_NONE, 0, 8'h60, 8'h04, 0, 0, 0, 8'h00);
        add("eoi_ns_ir2",     1, 8'h60, 1, C_EOI,  0, 8'h60, 8'h00, 0, 0, 0, 8'h00);
        add("ir5_unblocked",  1, 8'h60, 1, C_NONE, 0, 8'h60, 8'h00, 1, 0, 0, 8'h00);
        add("all_dropped",    3, 8'h00, 1, C_NONE, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add("ir4_req",        3, 8'h10, 1, C_NONE, 0, 8'h10, 8'h00, 1, 0, 0, 8'h00);
        add("ir4_fall1",      1, 8'h10, 0, C_NONE, 0, 8'h00, 8'h10, 0, 1, 0, 8'h00);
        add("ir4_rise1",      1, 8'h10, 1, C_NONE, 0, 8'h00, 8'h10, 0, 1, 0, 8'h00);
        add("ir4_fall2",      1, 8'h10, 0, C_NONE, 0, 8'h00, 8'h10, 0, 1, 1, 8'h44);
        add("ir4_rise2",      1, 8'h10, 1, C_NONE, 0, 8'h00, 8'h10, 0, 0, 0, 8'h00);
        add("eoi_rot_ir4",    1, 8'h10, 1, C_ROT,  0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add("ir3_ir5_req",    3, 8'h28, 1, C_NONE, 0, 8'h28, 8'h00, 1, 0, 0, 8'h00);
        add("rot_fall1",      1, 8'h28, 0, C_NONE, 0, 8'h08, 8'h20, 0, 1, 0, 8'h00);
        add("rot_rise1",      1, 8'h28, 1, C_NONE, 0, 8'h08, 8'h20, 0, 1, 0, 8'h00);
        add("rot_fall2",      1, 8'h28, 0, C_NONE, 0, 8'h08, 8'h20, 0, 1, 1, 8'h45);
        add("rot_rise2",      1, 8'h28, 1, C_NONE, 0, 8'h08, 8'h20, 0, 0, 0, 8'h00);
        add("ir3_below_ir5",  2, 8'h28, 1, C_NONE, 0, 8'h08, 8'h20, 0, 0, 0, 8'h00);
        add("eoi_spec_5",     1, 8'h28, 1, C_SPEC, 5, 8'h08, 8'h00, 0, 0, 0, 8'h00);
        add("ir3_now_valid",  1, 8'h28, 1, C_NONE, 0, 8'h08, 8'h00, 1, 0, 0, 8'h00);
        add("drop_ir3",       3, 8'h00, 1, C_NONE, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);

        // Reset state while rst_n is held low.
        #12;
        check("rst_irr",  irr,     8'h00);
        check("rst_isr",  isr,     8'h00);
        check("rst_int",  int_o,   8'h00);
        check("rst_dout", dout,    8'h00);
        check("rst_den",  dout_en, 8'h00);
        check("rst_busy", busy,    8'h00);
        rst_n = 1'b1;
        tick(1);

        foreach (vecs[i]) begin
            ir        = vecs[i].ir;
            inta_n    = vecs[i].inta_n;
            {eoi_cmd, eoi_spec, eoi_rot, set_prio} = vecs[i].cmd;
            eoi_level = vecs[i].lvl;
            tick(vecs[i].cyc);
            check({vecs[i].name, ".irr"},  irr,     vecs[i].e_irr);
            check({vecs[i].name, ".isr"},  isr,     vecs[i].e_isr);
            check({vecs[i].name, ".int"},  int_o,   8'(vecs[i].e_int));
            check({vecs[i].name, ".busy"}, busy,    8'(vecs[i].e_busy));
            check({vecs[i].name, ".den"},  dout_en, 8'(vecs[i].e_den));
            if (vecs[i].e_den) check({vecs[i].name, ".dout"}, dout, vecs[i].e_dout);
        end
        {eoi_cmd, eoi_spec, eoi_rot, set_prio} = C_NONE;

        // AEOI with auto-rotate. The table left lp=4. Serving IR0 moves lp to 0, so IR1 then beats IR0.
        aeoi = 1'b1; auto_rot = 1'b1;
        ir = 8'h01; tick(3);
        check("aeoi_ir0_int", int_o, 8'h01);
        pulse_inta(1'b0);
        check("aeoi_ir0_isr_set", isr, 8'h01);
        pulse_inta(1'b1);
        pulse_inta(1'b0);
        check("aeoi_ir0_dout", dout, 8'h40);
        pulse_inta(1'b1);
        check("aeoi_ir0_isr_clr", isr, 8'h00);
        check("aeoi_ir0_busy", busy, 8'h00);
        ir = 8'h00; tick(3);
        ir = 8'h03; tick(3);
        check("rot0_irr", irr, 8'h03);
        pulse_inta(1'b0);
        check("rot0_ir1_wins_isr", isr, 8'h02);
        check("rot0_irr_left", irr, 8'h01);
        pulse_inta(1'b1);
        pulse_inta(1'b0);
        check("rot0_dout", dout, 8'h41);
        pulse_inta(1'b1);
        check("rot0_isr_clr", isr, 8'h00);
        ir = 8'h00; tick(3);
        check("rot0_idle_int", int_o, 8'h00);

        // Level mode: the request is withdrawn before INTA, so the answer is spurious level 7.
        aeoi = 1'b0; auto_rot = 1'b0; ltim = 1'b1;
        ir = 8'h40; tick(3);
        check("lvl_ir6_irr", irr, 8'h40);
        check("lvl_ir6_int", int_o, 8'h01);
        ir = 8'h00; tick(3);
        check("lvl_ir6_irr_gone", irr, 8'h00);
        check("lvl_ir6_int_gone", int_o, 8'h00);
        pulse_inta(1'b0);
        check("spur_busy", busy, 8'h01);
        check("spur_isr", isr, 8'h00);
        pulse_inta(1'b1);
        pulse_inta(1'b0);
        check("spur_den", dout_en, 8'h01);
        check("spur_dout", dout, 8'h47);
        pulse_inta(1'b1);
        check("spur_end_isr", isr, 8'h00);
        check("spur_end_busy", busy, 8'h00);

        // Masking, then a reset asserted during ACK2.
        ltim = 1'b0; imr = 8'h10;
        ir = 8'h10; tick(3);
        check("mask_irr", irr, 8'h10);
        check("mask_int", int_o, 8'h00);
        imr = 8'h00; tick(1);
        check("unmask_int", int_o, 8'h01);
        pulse_inta(1'b0);
        pulse_inta(1'b1);
        pulse_inta(1'b0);
        check("pre_rst_den", dout_en, 8'h01);
        check("pre_rst_isr", isr, 8'h10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_den",  dout_en, 8'h00);
        check("mid_rst_busy", busy,    8'h00);
        check("mid_rst_isr",  isr,     8'h00);
        check("mid_rst_int",  int_o,   8'h00);
        #2;
        rst_n = 1'b1; inta_n = 1'b1; ir = 8'h00;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
